// File: rtl/approx_mul_pkg.sv
// Shared types for the sequential approximate multiplier family.
// Holds the mode and FSM encodings plus the effective-mode decode.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT      = 2'b00,
        MODE_TRUNC      = 2'b01,
        MODE_TRUNC_COMP = 2'b10,
        MODE_RSVD       = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Reserved mode and zero truncation both collapse to exact.
    function automatic mode_e eff_mode(
        input logic [1:0] mode,
        input logic       k_zero
    );
        if (k_zero || mode == MODE_EXACT || mode == MODE_RSVD)
            return MODE_EXACT;
        return mode_e'(mode);
    endfunction

endpackage

// File: rtl/approx_pp_mask.sv
// One shifted partial product with its low k columns optionally cleared.
// Purely combinational so array or pipelined variants can reuse it.
module approx_pp_mask import approx_mul_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic               i_b_bit,
    input  logic [KW-1:0]      i_cnt,
    input  logic [KW-1:0]      i_k,
    input  logic               i_trunc,
    output logic [2*WIDTH-1:0] o_pp
);

    logic [2*WIDTH-1:0] w_shift;
    logic [2*WIDTH-1:0] w_keep;

    // Shift the multiplicand into place and drop the truncated columns.
    always_comb begin
        w_shift = {{WIDTH{1'b0}}, i_a} << i_cnt;
        w_keep  = {(2*WIDTH){1'b1}} << i_k;
        o_pp    = '0;
        if (i_b_bit)
            o_pp = i_trunc ? (w_shift & w_keep) : w_shift;
    end

endmodule

// File: rtl/approx_mul_seq.sv
// Shift-add approximate multiplier, one multiplier bit per cycle.
// Truncation level and compensation are chosen per operation.
module approx_mul_seq import approx_mul_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_mode,
    input  logic [KW-1:0]      in_k,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_exact
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    mode_e              r_mode;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      r_cnt;
    logic               r_nz;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_out_p;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_exact;

    logic [KW-1:0]      w_k_clamp;
    logic               w_last;
    logic               w_b_bit;
    logic               w_trunc;
    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_comp;

    // Operand-side decode: clamp k, pick the current bit, build the bonus.
    always_comb begin
        w_k_clamp = (in_k > KW'(WIDTH)) ? KW'(WIDTH) : in_k;
        w_last    = (r_cnt == KW'(WIDTH));
        w_b_bit   = |(r_b & (WIDTH'(1) << r_cnt));
        w_trunc   = (r_mode != MODE_EXACT);
        w_comp    = '0;
        if (r_mode == MODE_TRUNC_COMP && r_nz)
            w_comp = {{(2*WIDTH-1){1'b0}}, 1'b1} << (r_k - KW'(1));
    end

    approx_pp_mask #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_pp (
        .i_a     (r_a),
        .i_b_bit (w_b_bit),
        .i_cnt   (r_cnt),
        .i_k     (r_k),
        .i_trunc (w_trunc),
        .o_pp    (w_pp)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; the extra BUSY step at cnt==WIDTH applies the bonus.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= MODE_EXACT;
            r_k         <= '0;
            r_cnt       <= '0;
            r_nz        <= 1'b0;
            r_acc       <= '0;
            r_out_p     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_exact <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_k    <= w_k_clamp;
                        r_mode <= eff_mode(in_mode, w_k_clamp == '0);
                        r_nz   <= (in_a != '0) && (in_b != '0);
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!w_last) begin
                        r_acc <= r_acc + w_pp;
                        r_cnt <= r_cnt + KW'(1);
                    end else begin
                        r_out_p     <= r_acc + w_comp;
                        r_out_exact <= (r_mode == MODE_EXACT);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_exact = r_out_exact;

endmodule
